// File: rtl/game_pkg.sv
// Shared encodings between the game state controller and the gameplay-side
// fight outcome tracker.
package game_pkg;

    typedef enum logic [2:0] {
        CTRL_MENU      = 3'b000,
        CTRL_COUNTDOWN = 3'b001,
        CTRL_GAMEPLAY  = 3'b010,
        CTRL_GAME_OVER = 3'b011
    } ctrl_state_e;

    typedef enum logic [1:0] {
        TRK_IDLE  = 2'b00,
        TRK_FIGHT = 2'b01,
        TRK_OVER  = 2'b10
    } trk_state_e;

    typedef enum logic [1:0] {
        REASON_NONE    = 2'b00,
        REASON_KO      = 2'b01,
        REASON_TIMEOUT = 2'b10
    } over_reason_e;

    localparam int HEALTH_W_DEF   = 8;
    localparam int MAX_HEALTH_DEF = 100;
    localparam int SECONDS_W      = 7;

endpackage

// File: rtl/fight_outcome_tracker_round_timer.sv
// Round clock: tick prescaler feeding a saturating seconds down-counter.
// 'expired' flags the cycle whose edge takes seconds_left from 1 to 0.
module round_timer
    import game_pkg::*;
#(
    parameter int TICKS_PER_SEC = 60,
    parameter int ROUND_SECONDS = 99
) (
    input  logic                 clk_game,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic                 run,
    output logic [SECONDS_W-1:0] seconds_left,
    output logic                 expired
);

    localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TICK_W-1:0]    TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
    localparam logic [SECONDS_W-1:0] SEC_LOAD  = SECONDS_W'(ROUND_SECONDS);

    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [SECONDS_W-1:0] sec_q, sec_d;
    logic                 wrap;

    // Reload beats a same-cycle wrap, so a reload never costs a second.
    always_comb begin
        tick_d = tick_q;
        sec_d  = sec_q;
        wrap   = run && !load && (tick_q == TICK_LAST);
        if (load) begin
            tick_d = '0;
            sec_d  = SEC_LOAD;
        end else if (run) begin
            if (tick_q == TICK_LAST) begin
                tick_d = '0;
                if (sec_q != '0) begin
                    sec_d = sec_q - SECONDS_W'(1);
                end
            end else begin
                tick_d = tick_q + TICK_W'(1);
            end
        end
    end

    always_ff @(posedge clk_game) begin
        if (!reset_n) begin
            tick_q <= '0;
            sec_q  <= SEC_LOAD;
        end else begin
            tick_q <= tick_d;
            sec_q  <= sec_d;
        end
    end

    assign seconds_left = sec_q;
    assign expired      = wrap && (sec_q == SECONDS_W'(1));

endmodule

// File: rtl/fight_outcome_tracker.sv
// Gameplay responder: tracks both players' health and the round clock, and
// reports KO / timeout outcomes back to the game state controller.
module fight_outcome_tracker
    import game_pkg::*;
#(
    parameter int MAX_HEALTH    = MAX_HEALTH_DEF,
    parameter int HEALTH_W      = HEALTH_W_DEF,
    parameter int TICKS_PER_SEC = 60,
    parameter int ROUND_SECONDS = 99
) (
    input  logic                 clk_game,
    input  logic                 reset_n,
    input  logic                 reset_gameplay,
    input  logic                 start_gameplay,
    input  logic                 timer_enable,
    input  logic                 timer_reset,
    input  logic                 p1_hit_valid,
    input  logic [HEALTH_W-1:0]  p1_hit_damage,
    input  logic                 p2_hit_valid,
    input  logic [HEALTH_W-1:0]  p2_hit_damage,
    output logic [HEALTH_W-1:0]  p1_health,
    output logic [HEALTH_W-1:0]  p2_health,
    output logic [SECONDS_W-1:0] seconds_left,
    output logic                 game_over_condition,
    output logic                 winner_p1,
    output logic                 winner_p2,
    output logic [1:0]           over_reason
);

    localparam logic [HEALTH_W-1:0] HEALTH_LOAD = HEALTH_W'(MAX_HEALTH);

    trk_state_e          state_q, state_d;
    over_reason_e        over_reason_q, over_reason_d;
    logic [HEALTH_W-1:0] p1_health_q, p1_health_d;
    logic [HEALTH_W-1:0] p2_health_q, p2_health_d;
    logic                game_over_q, game_over_d;
    logic                winner_p1_q, winner_p1_d;
    logic                winner_p2_q, winner_p2_d;
    logic [HEALTH_W-1:0] p1_post, p2_post;
    logic                in_fight, ko, timer_expired;

    function automatic logic [HEALTH_W-1:0] sat_sub(input logic [HEALTH_W-1:0] h,
                                                    input logic [HEALTH_W-1:0] d);
        return (d >= h) ? '0 : h - d;
    endfunction

    assign in_fight = (state_q == TRK_FIGHT);

    round_timer #(
        .TICKS_PER_SEC(TICKS_PER_SEC),
        .ROUND_SECONDS(ROUND_SECONDS)
    ) u_round_timer (
        .clk_game    (clk_game),
        .reset_n     (reset_n),
        .load        (reset_gameplay || (in_fight && timer_reset)),
        .run         (in_fight && timer_enable),
        .seconds_left(seconds_left),
        .expired     (timer_expired)
    );

    // Outcome is decided on post-hit health so a same-cycle hit counts.
    always_comb begin
        p1_post = p2_hit_valid ? sat_sub(p1_health_q, p2_hit_damage) : p1_health_q;
        p2_post = p1_hit_valid ? sat_sub(p2_health_q, p1_hit_damage) : p2_health_q;
        ko      = (p1_post == '0) || (p2_post == '0);

        state_d       = state_q;
        p1_health_d   = p1_health_q;
        p2_health_d   = p2_health_q;
        game_over_d   = game_over_q;
        winner_p1_d   = winner_p1_q;
        winner_p2_d   = winner_p2_q;
        over_reason_d = over_reason_q;

        if (reset_gameplay) begin
            state_d       = start_gameplay ? TRK_FIGHT : TRK_IDLE;
            p1_health_d   = HEALTH_LOAD;
            p2_health_d   = HEALTH_LOAD;
            game_over_d   = 1'b0;
            winner_p1_d   = 1'b0;
            winner_p2_d   = 1'b0;
            over_reason_d = REASON_NONE;
        end else begin
            case (state_q)
                TRK_IDLE: begin
                    if (start_gameplay) begin
                        state_d = TRK_FIGHT;
                    end
                end
                TRK_FIGHT: begin
                    p1_health_d = p1_post;
                    p2_health_d = p2_post;
                    if (ko) begin
                        state_d       = TRK_OVER;
                        game_over_d   = 1'b1;
                        over_reason_d = REASON_KO;
                        winner_p1_d   = (p2_post == '0) && (p1_post != '0);
                        winner_p2_d   = (p1_post == '0) && (p2_post != '0);
                    end else if (timer_expired) begin
                        state_d       = TRK_OVER;
                        game_over_d   = 1'b1;
                        over_reason_d = REASON_TIMEOUT;
                        winner_p1_d   = p1_post > p2_post;
                        winner_p2_d   = p2_post > p1_post;
                    end
                end
                TRK_OVER: begin
                end
                default: begin
                    state_d = TRK_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_game) begin
        if (!reset_n) begin
            state_q       <= TRK_IDLE;
            p1_health_q   <= HEALTH_LOAD;
            p2_health_q   <= HEALTH_LOAD;
            game_over_q   <= 1'b0;
            winner_p1_q   <= 1'b0;
            winner_p2_q   <= 1'b0;
            over_reason_q <= REASON_NONE;
        end else begin
            state_q       <= state_d;
            p1_health_q   <= p1_health_d;
            p2_health_q   <= p2_health_d;
            game_over_q   <= game_over_d;
            winner_p1_q   <= winner_p1_d;
            winner_p2_q   <= winner_p2_d;
            over_reason_q <= over_reason_d;
        end
    end

    assign p1_health           = p1_health_q;
    assign p2_health           = p2_health_q;
    assign game_over_condition = game_over_q;
    assign winner_p1           = winner_p1_q;
    assign winner_p2           = winner_p2_q;
    assign over_reason         = over_reason_q;

endmodule

// File: tb/tb_fight_outcome_tracker.sv
// Table-driven directed vectors followed by randomized play checked against
// a behavioural model of the round rules (short round: 4 ticks/s, 3 s).
module tb_fight_outcome_tracker;

    localparam int TPS   = 4;
    localparam int ROUND = 3;
    localparam int MAXH  = 100;

    typedef struct {
        logic       rst_n, rg, st, te, tr, v1;
        logic [7:0] d1;
        logic       v2;
        logic [7:0] d2;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic [7:0] h1, h2;
        logic [6:0] secs;
        logic       go, w1, w2;
        logic [1:0] r;
    } vec_t;

    logic       clk_game = 1'b0;
    logic       reset_n = 1'b0, reset_gameplay = 1'b0, start_gameplay = 1'b0;
    logic       timer_enable = 1'b0, timer_reset = 1'b0;
    logic       p1_hit_valid = 1'b0, p2_hit_valid = 1'b0;
    logic [7:0] p1_hit_damage = '0, p2_hit_damage = '0;
    logic [7:0] p1_health, p2_health;
    logic [6:0] seconds_left;
    logic       game_over_condition, winner_p1, winner_p2;
    logic [1:0] over_reason;

    int checks = 0;
    int failures = 0;

    // Behavioural model: phase 0 idle, 1 fighting, 2 over; the clock is kept
    // as total enabled ticks since the last reload.
    int m_phase = 0, m_h1 = MAXH, m_h2 = MAXH, m_el = 0;
    int m_go = 0, m_w1 = 0, m_w2 = 0, m_r = 0;

    vec_t tbl[$];

    fight_outcome_tracker #(
        .MAX_HEALTH(MAXH), .HEALTH_W(8), .TICKS_PER_SEC(TPS), .ROUND_SECONDS(ROUND)
    ) dut (
        .clk_game(clk_game), .reset_n(reset_n), .reset_gameplay(reset_gameplay),
        .start_gameplay(start_gameplay), .timer_enable(timer_enable),
        .timer_reset(timer_reset), .p1_hit_valid(p1_hit_valid),
        .p1_hit_damage(p1_hit_damage), .p2_hit_valid(p2_hit_valid),
        .p2_hit_damage(p2_hit_damage), .p1_health(p1_health), .p2_health(p2_health),
        .seconds_left(seconds_left), .game_over_condition(game_over_condition),
        .winner_p1(winner_p1), .winner_p2(winner_p2), .over_reason(over_reason)
    );

    always #5 clk_game = ~clk_game;

    function automatic int secs_of(input int el);
        return (el / TPS >= ROUND) ? 0 : ROUND - el / TPS;
    endfunction

    function automatic stim_t mks(input logic rst_n, rg, st, te, tr, v1,
                                  input logic [7:0] d1, input logic v2,
                                  input logic [7:0] d2);
        stim_t s;
        s.rst_n = rst_n; s.rg = rg; s.st = st; s.te = te; s.tr = tr;
        s.v1 = v1; s.d1 = d1; s.v2 = v2; s.d2 = d2;
        return s;
    endfunction

    function automatic vec_t mk(input stim_t s, input logic [7:0] h1, h2,
                                input logic [6:0] secs, input logic go, w1, w2,
                                input logic [1:0] r);
        vec_t v;
        v.s = s; v.h1 = h1; v.h2 = h2; v.secs = secs;
        v.go = go; v.w1 = w1; v.w2 = w2; v.r = r;
        return v;
    endfunction

    task automatic model_step(input stim_t s);
        int n1, n2, old_s, new_s;
        if (!s.rst_n || s.rg) begin
            m_h1 = MAXH; m_h2 = MAXH; m_el = 0;
            m_go = 0; m_w1 = 0; m_w2 = 0; m_r = 0;
            m_phase = (s.rst_n && s.st) ? 1 : 0;
        end else if (m_phase == 0) begin
            if (s.st) m_phase = 1;
        end else if (m_phase == 1) begin
            n1 = s.v2 ? ((int'(s.d2) >= m_h1) ? 0 : m_h1 - int'(s.d2)) : m_h1;
            n2 = s.v1 ? ((int'(s.d1) >= m_h2) ? 0 : m_h2 - int'(s.d1)) : m_h2;
            old_s = secs_of(m_el);
            if (s.tr) m_el = 0;
            else if (s.te) m_el = m_el + 1;
            new_s = secs_of(m_el);
            m_h1 = n1; m_h2 = n2;
            if (n1 == 0 || n2 == 0) begin
                m_phase = 2; m_go = 1; m_r = 1;
                m_w1 = (n2 == 0 && n1 != 0) ? 1 : 0;
                m_w2 = (n1 == 0 && n2 != 0) ? 1 : 0;
            end else if (old_s == 1 && new_s == 0) begin
                m_phase = 2; m_go = 1; m_r = 2;
                m_w1 = (n1 > n2) ? 1 : 0;
                m_w2 = (n2 > n1) ? 1 : 0;
            end
        end
    endtask

    // Drive on the falling edge, let the DUT sample, then look 1 unit later.
    task automatic applyStimulus(input stim_t s);
        @(negedge clk_game);
        reset_n = s.rst_n; reset_gameplay = s.rg; start_gameplay = s.st;
        timer_enable = s.te; timer_reset = s.tr;
        p1_hit_valid = s.v1; p1_hit_damage = s.d1;
        p2_hit_valid = s.v2; p2_hit_damage = s.d2;
        model_step(s);
        @(posedge clk_game);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] h1, h2,
                               input logic [6:0] secs, input logic go, w1, w2,
                               input logic [1:0] r);
        checks++;
        if ({p1_health, p2_health, seconds_left, game_over_condition, winner_p1,
             winner_p2, over_reason} !== {h1, h2, secs, go, w1, w2, r}) begin
            failures++;
            $display("[TB] FAIL %s: got h1=%0d h2=%0d s=%0d go=%0b w1=%0b w2=%0b r=%0d expected h1=%0d h2=%0d s=%0d go=%0b w1=%0b w2=%0b r=%0d",
                     name, p1_health, p2_health, seconds_left, game_over_condition,
                     winner_p1, winner_p2, over_reason, h1, h2, secs, go, w1, w2, r);
        end
    endtask

    initial begin
        stim_t s;
        stim_t idle_s;
        stim_t te_s;
        idle_s = mks(1, 0, 0, 0, 0, 0, 0, 0, 0);
        te_s   = mks(1, 0, 0, 1, 0, 0, 0, 0, 0);

        // Reset, simultaneous reset_gameplay+start, repeated P1 hits to KO.
        tbl.push_back(mk(mks(0, 0, 0, 0, 0, 0, 0, 0, 0), 100, 100, 3, 0, 0, 0, 0));
        tbl.push_back(mk(mks(1, 1, 1, 0, 0, 0, 0, 0, 0), 100, 100, 3, 0, 0, 0, 0));
        tbl.push_back(mk(mks(1, 0, 0, 0, 0, 1, 30, 0, 0), 100, 70, 3, 0, 0, 0, 0));
        tbl.push_back(mk(mks(1, 0, 0, 0, 0, 1, 30, 0, 0), 100, 40, 3, 0, 0, 0, 0));
        tbl.push_back(mk(mks(1, 0, 0, 0, 0, 1, 30, 0, 0), 100, 10, 3, 0, 0, 0, 0));
        tbl.push_back(mk(mks(1, 0, 0, 0, 0, 1, 30, 0, 0), 100, 0, 3, 1, 1, 0, 1));
        // OVER ignores hits, start, timer controls; reset_gameplay clears.
        tbl.push_back(mk(mks(1, 0, 1, 1, 1, 1, 30, 1, 50), 100, 0, 3, 1, 1, 0, 1));
        tbl.push_back(mk(mks(1, 1, 0, 0, 0, 0, 0, 0, 0), 100, 100, 3, 0, 0, 0, 0));
        // IDLE ignores hits and the clock.
        tbl.push_back(mk(mks(1, 0, 0, 1, 0, 1, 50, 1, 50), 100, 100, 3, 0, 0, 0, 0));
        tbl.push_back(mk(mks(1, 0, 1, 0, 0, 0, 0, 0, 0), 100, 100, 3, 0, 0, 0, 0));
        // Double KO draw.
        tbl.push_back(mk(mks(1, 0, 0, 0, 0, 1, 95, 1, 95), 5, 5, 3, 0, 0, 0, 0));
        tbl.push_back(mk(mks(1, 0, 0, 0, 0, 1, 10, 1, 10), 0, 0, 3, 1, 0, 0, 1));
        // Zero damage no-op, then 60/80 and a timeout with a stall.
        tbl.push_back(mk(mks(1, 1, 1, 0, 0, 0, 0, 0, 0), 100, 100, 3, 0, 0, 0, 0));
        tbl.push_back(mk(mks(1, 0, 0, 0, 0, 1, 0, 1, 0), 100, 100, 3, 0, 0, 0, 0));
        tbl.push_back(mk(mks(1, 0, 0, 0, 0, 0, 0, 1, 40), 60, 100, 3, 0, 0, 0, 0));
        tbl.push_back(mk(mks(1, 0, 0, 0, 0, 1, 20, 0, 0), 60, 80, 3, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(te_s, 60, 80, 3, 0, 0, 0, 0));
        tbl.push_back(mk(te_s, 60, 80, 2, 0, 0, 0, 0));
        for (int i = 0; i < 2; i++) tbl.push_back(mk(idle_s, 60, 80, 2, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(te_s, 60, 80, 2, 0, 0, 0, 0));
        tbl.push_back(mk(te_s, 60, 80, 1, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(te_s, 60, 80, 1, 0, 0, 0, 0));
        tbl.push_back(mk(te_s, 60, 80, 0, 1, 0, 1, 2));
        // Equal-health timeout draw.
        tbl.push_back(mk(mks(1, 1, 1, 0, 0, 0, 0, 0, 0), 100, 100, 3, 0, 0, 0, 0));
        for (int i = 0; i < 12; i++)
            tbl.push_back(mk(te_s, 100, 100, 7'(3 - (i + 1) / 4), (i == 11),
                             1'b0, 1'b0, (i == 11) ? 2'd2 : 2'd0));
        // reset_n mid-fight discards a same-cycle hit.
        tbl.push_back(mk(mks(1, 1, 1, 0, 0, 0, 0, 0, 0), 100, 100, 3, 0, 0, 0, 0));
        tbl.push_back(mk(mks(1, 0, 0, 0, 0, 1, 10, 0, 0), 100, 90, 3, 0, 0, 0, 0));
        tbl.push_back(mk(mks(0, 0, 0, 0, 0, 0, 0, 1, 50), 100, 100, 3, 0, 0, 0, 0));
        tbl.push_back(mk(mks(1, 0, 1, 0, 0, 0, 0, 0, 0), 100, 100, 3, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(te_s, 100, 100, 3, 0, 0, 0, 0));
        tbl.push_back(mk(mks(1, 0, 0, 1, 1, 0, 0, 0, 0), 100, 100, 3, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(te_s, 100, 100, 3, 0, 0, 0, 0));
        tbl.push_back(mk(te_s, 100, 100, 2, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(te_s, 100, 100, 2, 0, 0, 0, 0));
        tbl.push_back(mk(te_s, 100, 100, 1, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(te_s, 100, 100, 1, 0, 0, 0, 0));
        // KO on the same edge as the 1 -> 0 tick: KO wins.
        tbl.push_back(mk(mks(1, 0, 0, 1, 0, 1, 255, 0, 0), 100, 0, 0, 1, 1, 0, 1));

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].s);
            checkOutput($sformatf("vec%0d", i), tbl[i].h1, tbl[i].h2, tbl[i].secs,
                        tbl[i].go, tbl[i].w1, tbl[i].w2, tbl[i].r);
        end

        applyStimulus(mks(0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 800; i++) begin
            s.rst_n = ($urandom_range(0, 99) != 0);
            s.rg    = ($urandom_range(0, 24) == 0);
            s.st    = ($urandom_range(0, 5) == 0);
            s.te    = ($urandom_range(0, 3) != 0);
            s.tr    = ($urandom_range(0, 39) == 0);
            s.v1    = ($urandom_range(0, 4) == 0);
            s.d1    = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                                   : 8'($urandom_range(0, 30));
            s.v2    = ($urandom_range(0, 4) == 0);
            s.d2    = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                                   : 8'($urandom_range(0, 30));
            applyStimulus(s);
            checkOutput($sformatf("rand%0d", i), 8'(m_h1), 8'(m_h2), 7'(secs_of(m_el)),
                        m_go[0], m_w1[0], m_w2[0], 2'(m_r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fight_outcome_tracker.md
Name: fight_outcome_tracker

Overview:
Gameplay-side responder to the game state controller. It consumes the controller's start_gameplay, reset_gameplay, timer_enable and timer_reset. It tracks both players' health and the round countdown clock. It produces game_over_condition, winner_p1 and winner_p2 back to the controller, plus health and time values for the HUD.

Parameters:
MAX_HEALTH, 100, health loaded at round start (must fit HEALTH_W)
HEALTH_W, 8, width of health and damage values
TICKS_PER_SEC, 60, clk_game ticks per displayed second
ROUND_SECONDS, 99, round length in seconds (fits 7 bits)

Ports:
clk_game  in  1  60Hz game clock
reset_n  in  1  synchronous, active-low reset
reset_gameplay  in  1  level; clear round to fresh state
start_gameplay  in  1  one-cycle pulse; begin fight
timer_enable  in  1  level; allow round clock to run
timer_reset  in  1  level; reload round clock
p1_hit_valid  in  1  P1 landed a hit on P2 this cycle
p1_hit_damage  in  HEALTH_W  damage dealt to P2
p2_hit_valid  in  1  P2 landed a hit on P1 this cycle
p2_hit_damage  in  HEALTH_W  damage dealt to P1
p1_health  out  HEALTH_W  current P1 health
p2_health  out  HEALTH_W  current P2 health
seconds_left  out  7  remaining round seconds
game_over_condition  out  1  level; round finished
winner_p1  out  1  P1 won
winner_p2  out  1  P2 won (both winner bits 0 = draw)
over_reason  out  2  00 none, 01 KO, 10 timeout

Behaviour:
- Interface: one clock, clk_game. Reset is synchronous and active-low: reset_n sampled on posedge clk_game.
- All outputs are registered.
- Reset values: p1_health = p2_health = MAX_HEALTH, seconds_left = ROUND_SECONDS, game_over_condition = 0, winner_p1 = winner_p2 = 0, over_reason = 00. FSM resets to IDLE and the tick counter to 0.
- FSM states: IDLE, FIGHT, OVER.
- Priority: reset_n > reset_gameplay > state logic.
- reset_gameplay = 1: loads all reset values and returns to IDLE, from any state.
  - If start_gameplay = 1 in the same cycle (the controller's last countdown cycle), the next state is FIGHT with fresh values.
- IDLE -> FIGHT on start_gameplay. Hits are ignored and the clock holds in IDLE.
- FIGHT:
  - p2_hit_valid reduces p1_health by p2_hit_damage; p1_hit_valid reduces p2_health by p1_hit_damage.
  - Subtraction saturates at 0: if damage >= health, health becomes 0.
  - Both hits in one cycle are applied simultaneously.
  - A hit with valid = 1 and damage = 0 is a no-op.
- Round clock, running in FIGHT only:
  - The tick counter counts 0..TICKS_PER_SEC-1 while timer_enable = 1 and holds otherwise.
  - On wrap, seconds_left decrements and stops at 0.
  - timer_reset = 1 clears the tick counter and reloads seconds_left to ROUND_SECONDS. It wins over a same-cycle tick.
- KO: post-hit p1_health == 0 or p2_health == 0. Next state OVER, over_reason = 01.
  - Only P2 at 0: winner_p1 = 1.
  - Only P1 at 0: winner_p2 = 1.
  - Both at 0 in the same cycle: draw (both winner bits 0).
- Timeout: seconds_left transitions 1 -> 0. Next state OVER, over_reason = 10. The higher post-hit health wins; equal health is a draw.
- KO and timeout in the same cycle: KO takes precedence.
- Latency: game_over_condition, winner bits and over_reason are asserted 1 cycle after the deciding hit or tick edge. All are set in the same cycle as the transition into OVER.
- OVER:
  - Health, seconds, winner bits and reason are frozen; hits and start_gameplay are ignored.
  - game_over_condition holds at 1 until reset_gameplay or reset_n.
- winner_p1 and winner_p2 are never 1 simultaneously.
- While the FSM is not in OVER, game_over_condition, the winner bits and over_reason are 0.

Decomposition:
- Shared package game_pkg holds:
  - the controller state encodings (MENU 000, COUNTDOWN 001, GAMEPLAY 010, GAME_OVER 011);
  - tracker FSM encodings;
  - over_reason codes;
  - HEALTH_W and MAX_HEALTH defaults.
- One sub-module, round_timer: the tick prescaler plus seconds down-counter with enable, reload and an expired pulse.
- Health update, outcome decision and the FSM live in the top module.

Test Plan:
1. Reset, then reset_gameplay + start_gameplay in the same cycle -> FIGHT next cycle, health 100/100, seconds_left 99, game_over_condition 0.
2. In FIGHT, p1_hit_valid with damage 30 four times -> p2_health 70, 40, 10, then 0 (saturated). game_over_condition = 1, winner_p1 = 1, over_reason = 01 one cycle after the 4th hit.
3. With p1_health 5 and p2_health 5, both hits with damage 10 in one cycle -> both health 0, draw (winner_p1 = winner_p2 = 0), over_reason = 01.
4. Override TICKS_PER_SEC = 4, ROUND_SECONDS = 3, timer_enable = 1, p1_health 60, p2_health 80 -> seconds_left 3 -> 2 -> 1 -> 0 every 4 cycles. Timeout fires with winner_p2 = 1, over_reason = 10. Toggling timer_enable low must stall the count.
5. In OVER, apply hits and start_gameplay -> all outputs unchanged. Then assert reset_gameplay -> IDLE, health 100/100, game_over_condition 0.
6. Assert reset_n = 0 mid-FIGHT with a same-cycle hit -> the hit is discarded and all outputs take their reset values on the next edge. Also assert timer_reset on a wrap cycle -> seconds_left reloads to ROUND_SECONDS with no decrement.
